inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl_if.sv | 24 ++
 rtl/inst_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller (master) and memory (slave).
interface inst_fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read feeding a small in-order buffer.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a PC; accepts only when a buffer slot is free
// REQ   | mem_req asserted with the latched address until granted
// WAIT  | read granted, waiting for mem_rvalid to push the result
// DRAIN | read was flushed; swallow its mem_rvalid before returning to IDLE
module inst_fetch_ctrl #(
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         pc_in,
  input  logic                pc_valid,
  output logic                pc_ready,
  inst_fetch_ctrl_if.master   mem,
  output logic                inst_valid,
  output logic [31:0]         inst_out,
  output logic [31:0]         inst_pc,
  input  logic                inst_ready,
  input  logic                flush,
  output logic                addr_fault
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [31:0]    addr_q;
  logic [31:0]    buf_inst [BUF_DEPTH];
  logic [31:0]    buf_pc   [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           accept, misaligned, issue, push, pop;

  assign pc_ready   = rstn && (state_q == IDLE) && (count_q < CW'(BUF_DEPTH)) && !flush;
  assign accept     = pc_valid && pc_ready;
  assign issue      = accept && !misaligned;
  assign inst_valid = (count_q != '0);
  assign push       = (state_q == WAIT) && mem.mem_rvalid && !flush;
  assign pop        = inst_valid && inst_ready && !flush;

  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_addr = {addr_q[31:2], 2'b00};

  // Stale entries stay in storage after a pop or flush, so the head is masked when empty.
  assign inst_out = inst_valid ? buf_inst[rd_ptr_q] : 32'h0;
  assign inst_pc  = inst_valid ? buf_pc[rd_ptr_q]   : 32'h0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign misaligned = (pc_in[1:0] != 2'b00);
  assign addr_fault = fault_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= accept && misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign addr_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (issue) state_d = REQ;
      // A grant in the same cycle as flush means a read is in flight, so it must be drained.
      REQ: begin
        if (flush)              state_d = mem.mem_gnt ? DRAIN : IDLE;
        else if (mem.mem_gnt)   state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid)     state_d = IDLE;
        else if (flush)         state_d = DRAIN;
      end
      DRAIN: if (mem.mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (issue) addr_q <= pc_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr_q] <= mem.mem_rdata;
      buf_pc[wr_ptr_q]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a hand-driven memory port.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        flush;
  logic        addr_fault;
  int          checks = 0;
  int          errors = 0;

  inst_fetch_ctrl_if mem_if ();

  inst_fetch_ctrl #(.BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .mem        (mem_if.master),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .flush      (flush),
    .addr_fault (addr_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    pc_in = a; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = d;
    tick();
    mem_if.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pc_valid = 1'b1; pc_in = 32'h0; inst_ready = 1'b0; flush = 1'b0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    tick(); tick();
    checks++;
    if ({pc_ready, mem_if.mem_req, inst_valid, addr_fault} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {pc_ready, mem_if.mem_req, inst_valid, addr_fault});
    end
    checks++;
    if ({mem_if.mem_addr, inst_out, inst_pc} !== 96'h0) begin
      errors++; $display("FAIL reset_buses: addr %h out %h pc %h want 0", mem_if.mem_addr, inst_out, inst_pc);
    end
    rstn = 1'b1; pc_valid = 1'b0;
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", pc_ready); end
  endtask

  task automatic test_basic();
    pc_in = 32'h0; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    checks++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0) begin
      errors++; $display("FAIL basic_req: req %b addr %h want 1 00000000", mem_if.mem_req, mem_if.mem_addr);
    end
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h20080005;
    checks++;
    if (mem_if.mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL basic_wait: req %b valid %b want 0 0", mem_if.mem_req, inst_valid);
    end
    tick();
    mem_if.mem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 32'h20080005 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL basic_inst: valid %b out %h pc %h want 1 20080005 00000000", inst_valid, inst_out, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: valid %b want 0", inst_valid); end
  endtask

  task automatic test_full();
    inst_ready = 1'b0;
    do_fetch(32'h0, 32'hAAAA0000);
    do_fetch(32'h4, 32'hAAAA0004);
    pc_in = 32'h8; pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc_ready !== 1'b0 || mem_if.mem_req !== 1'b0) begin
        errors++; $display("FAIL full_hold%0d: ready %b req %b want 0 0", i, pc_ready, mem_if.mem_req);
      end
      tick();
    end
    checks++;
    if (inst_out !== 32'hAAAA0000 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL full_head: out %h pc %h want aaaa0000 00000000", inst_out, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    checks++;
    if (pc_ready !== 1'b1 || inst_pc !== 32'h4 || inst_out !== 32'hAAAA0004) begin
      errors++; $display("FAIL full_after_pop: ready %b pc %h out %h want 1 4 aaaa0004", pc_ready, inst_pc, inst_out);
    end
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    checks++;
    if (mem_if.mem_addr !== 32'h8 || mem_if.mem_req !== 1'b1) begin
      errors++; $display("FAIL full_fetch8: addr %h req %b want 8 1", mem_if.mem_addr, mem_if.mem_req);
    end
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hAAAA0008;
    inst_ready = 1'b1;
    tick();
    mem_if.mem_rvalid = 1'b0; inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_out !== 32'hAAAA0008 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL full_push_pop: valid %b pc %h out %h ready %b want 1 8 aaaa0008 1", inst_valid, inst_pc, inst_out, pc_ready);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL full_drained: valid %b want 0", inst_valid); end
  endtask

  task automatic test_flush_wait();
    pc_in = 32'h10; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    checks++;
    if (mem_if.mem_addr !== 32'h10) begin errors++; $display("FAIL fw_addr: got %h want 10", mem_if.mem_addr); end
    tick();
    mem_if.mem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; pc_in = 32'h40; pc_valid = 1'b1;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (pc_ready !== 1'b0) begin errors++; $display("FAIL fw_drain_ready: got %b want 0", pc_ready); end
    tick();
    mem_if.mem_rvalid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL fw_discard: valid %b ready %b want 0 1", inst_valid, pc_ready);
    end
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    checks++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h40) begin
      errors++; $display("FAIL fw_refetch: req %b addr %h want 1 40", mem_if.mem_req, mem_if.mem_addr);
    end
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h11111111;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 32'h11111111 || inst_pc !== 32'h40) begin
      errors++; $display("FAIL fw_inst: valid %b out %h pc %h want 1 11111111 40", inst_valid, inst_out, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_flush_misc();
    pc_in = 32'h20; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL fr_req: got %b want 1", mem_if.mem_req); end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (mem_if.mem_req !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL fr_idle: req %b ready %b want 0 1", mem_if.mem_req, pc_ready);
    end
    pc_in = 32'h24; pc_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (pc_ready !== 1'b0) begin errors++; $display("FAIL fi_ready: got %b want 0", pc_ready); end
    tick();
    flush = 1'b0; pc_valid = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL fi_noreq: got %b want 0", mem_if.mem_req); end
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL stray_idle: valid %b want 0", inst_valid); end
    do_fetch(32'h70, 32'h77777777);
    pc_in = 32'h60; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h66666666;
    flush = 1'b1; inst_ready = 1'b1;
    tick();
    mem_if.mem_rvalid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL flush_override: valid %b ready %b want 0 1", inst_valid, pc_ready);
    end
  endtask

  task automatic test_stream();
    logic [31:0] next_pc, rd_pend;
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    bit          acc_pend, rv_pend;
    inst_ready = 1'b0;
    do_fetch(32'h0, 32'hC0DE0000);
    do_fetch(32'h4, 32'hC0DE0004);
    next_pc = 32'h8; pc_in = next_pc; pc_valid = 1'b1;
    mem_if.mem_gnt = 1'b1; inst_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got_pc.size() < 4; cyc++) begin
      #1;
      if (inst_valid) begin got_pc.push_back(inst_pc); got_data.push_back(inst_out); end
      acc_pend = pc_valid && pc_ready;
      rv_pend  = mem_if.mem_req && mem_if.mem_gnt;
      rd_pend  = 32'hC0DE0000 | mem_if.mem_addr;
      tick();
      mem_if.mem_rvalid = rv_pend; mem_if.mem_rdata = rd_pend;
      if (acc_pend) begin
        next_pc = next_pc + 32'h4; pc_in = next_pc; pc_valid = (next_pc <= 32'hC);
      end
    end
    mem_if.mem_rvalid = 1'b0; mem_if.mem_gnt = 1'b0; pc_valid = 1'b0;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (got_pc.size() != 4) begin errors++; $display("FAIL stream_count: got %0d want 4", got_pc.size()); end
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(i * 4) || got_data[i] !== (32'hC0DE0000 | 32'(i * 4))) begin
        errors++; $display("FAIL stream_order%0d: pc %h data %h want %h %h", i, got_pc[i], got_data[i], 32'(i * 4), 32'hC0DE0000 | 32'(i * 4));
      end
    end
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_nodup: valid %b want 0", inst_valid); end
  endtask

  task automatic test_align();
    pc_in = 32'h6; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (addr_fault !== 1'b1 || mem_if.mem_req !== 1'b0) begin
      errors++; $display("FAIL align_fault: fault %b req %b want 1 0", addr_fault, mem_if.mem_req);
    end
    tick();
    checks++;
    if (addr_fault !== 1'b0 || mem_if.mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL align_after: fault %b req %b valid %b want 0 0 0", addr_fault, mem_if.mem_req, inst_valid);
    end
`else
    mem_if.mem_gnt = 1'b1;
    checks++;
    if (mem_if.mem_addr !== 32'h4 || mem_if.mem_req !== 1'b1 || addr_fault !== 1'b0) begin
      errors++; $display("FAIL align_addr: addr %h req %b fault %b want 4 1 0", mem_if.mem_addr, mem_if.mem_req, addr_fault);
    end
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h000000A1;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 32'h000000A1) begin
      errors++; $display("FAIL align_inst: valid %b out %h want 1 000000a1", inst_valid, inst_out);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    do_fetch(32'h50, 32'h55AA55AA);
    pc_in = 32'h30; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || mem_if.mem_addr !== 32'h30) begin
      errors++; $display("FAIL rm_pre: valid %b addr %h want 1 30", inst_valid, mem_if.mem_addr);
    end
    rstn = 1'b0; pc_valid = 1'b1;
    #1;
    checks++;
    if ({pc_ready, mem_if.mem_req, inst_valid, addr_fault} !== 4'b0000) begin
      errors++; $display("FAIL rm_flags: got %b want 0000", {pc_ready, mem_if.mem_req, inst_valid, addr_fault});
    end
    checks++;
    if ({mem_if.mem_addr, inst_out, inst_pc} !== 96'h0) begin
      errors++; $display("FAIL rm_buses: addr %h out %h pc %h want 0", mem_if.mem_addr, inst_out, inst_pc);
    end
    tick();
    rstn = 1'b1; pc_valid = 1'b0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || mem_if.mem_req !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL rm_stray: valid %b req %b ready %b want 0 0 1", inst_valid, mem_if.mem_req, pc_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush_wait();
    test_flush_misc();
    test_stream();
    test_align();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
